// File: rtl/dtm_pkg.sv
// dtm_pkg: shared types and constants for the JTAG debug transport module.
//   - DMI op encodings, DMI status encodings
//   - DTMCS register layout
//   - DMI access FSM states
//   - DTM version constant
package dtm_pkg;

    localparam logic [3:0] DtmVersion = 4'd1;

    typedef enum logic [1:0] {
        DmiNop   = 2'd0,
        DmiRead  = 2'd1,
        DmiWrite = 2'd2
    } dmi_op_e;

    typedef enum logic [1:0] {
        DmiOk     = 2'd0,
        DmiFailed = 2'd2,
        DmiBusy   = 2'd3
    } dmi_status_e;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } dmi_state_e;

endpackage

// File: rtl/dtm_shift_reg.sv
// dtm_shift_reg: JTAG data register shift stage.
//   clk_i/rst_ni  : TCK and asynchronous active-low reset
//   clear_i       : synchronous clear, wins over capture/shift
//   capture_i     : parallel load of capture_data_i
//   shift_i       : shift right, tdi_i enters at the MSB
//   q_o           : full register contents (used on update)
//   tdo_o         : register LSB
module dtm_shift_reg #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             capture_i,
    input  logic             shift_i,
    input  logic             tdi_i,
    input  logic [Width-1:0] capture_data_i,
    output logic [Width-1:0] q_o,
    output logic             tdo_o
);

    logic [Width-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clear_i) begin
            sr_d = '0;
        end else if (capture_i) begin
            sr_d = capture_data_i;
        end else if (shift_i) begin
            sr_d = {tdi_i, sr_q[Width-1:1]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o   = sr_q;
    assign tdo_o = sr_q[0];

endmodule

// File: rtl/dtm_dmi_ctrl.sv
// dtm_dmi_ctrl: DMI access controller of the JTAG DTM (TCK domain).
// Owns the DTMCS and DMI data registers, turns DMI update-DR into a
// valid/ready request/response transaction and keeps sticky dmistat.
//   tck_i, trst_ni          : clock, asynchronous active-low reset
//   dmi_clear_i             : TAP Test-Logic-Reset (hard reset)
//   capture_i/shift_i/update_i, tdi_i : TAP DR strobes and serial input
//   dtmcs_select_i/dtmcs_tdo_o, dmi_select_i/dmi_tdo_o : DR select / LSB
//   dmi_req_*               : request channel toward the debug module
//   dmi_resp_*              : response channel from the debug module
//   dmi_hardreset_o         : one-cycle pulse on hard reset
// Build option: define DTM_DMI_HARDRESET_EN to honour DTMCS.dmihardreset
// (bit 17) and drive dmi_hardreset_o; otherwise bit 17 is ignored and the
// pulse output is tied low.
module dtm_dmi_ctrl
    import dtm_pkg::*;
#(
    parameter int unsigned AddrWidth  = 7,
    parameter int unsigned IdleCycles = 1
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 dmi_clear_i,
    input  logic                 capture_i,
    input  logic                 shift_i,
    input  logic                 update_i,
    input  logic                 tdi_i,
    input  logic                 dtmcs_select_i,
    output logic                 dtmcs_tdo_o,
    input  logic                 dmi_select_i,
    output logic                 dmi_tdo_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [31:0]          dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_op_i,
    output logic                 dmi_hardreset_o
);

    localparam int unsigned DmiWidth = AddrWidth + 34;

    dmi_state_e           state_q, state_d;
    logic [1:0]           dmistat_q, dmistat_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic [1:0]           op_q, op_d;

    logic                 dtmcs_cap, dtmcs_upd, dmi_cap, dmi_upd;
    logic                 completing, busy_now;
    dtmcs_t               dtmcs_cap_data;
    logic [31:0]          dtmcs_sr;
    logic [DmiWidth-1:0]  dmi_sr, dmi_cap_data;
    logic [1:0]           upd_op;

    assign dtmcs_cap = capture_i & dtmcs_select_i;
    assign dtmcs_upd = update_i  & dtmcs_select_i;
    assign dmi_cap   = capture_i & dmi_select_i;
    assign dmi_upd   = update_i  & dmi_select_i;
    assign upd_op    = dmi_sr[1:0];

    always_comb begin
        dtmcs_cap_data         = '0;
        dtmcs_cap_data.version = DtmVersion;
        dtmcs_cap_data.abits   = 6'(AddrWidth);
        dtmcs_cap_data.dmistat = dmistat_q;
        dtmcs_cap_data.idle    = 3'(IdleCycles);
    end

`ifdef DTM_DMI_HARDRESET_EN
    logic hardreset_q, hardreset_d;
    logic unused_dtmcs;
    assign unused_dtmcs = ^{dtmcs_sr[31:18], dtmcs_sr[15:0]};
`else
    logic unused_dtmcs;
    assign unused_dtmcs = ^{dtmcs_sr[31:17], dtmcs_sr[15:0]};
`endif

    // Evaluation order matters: a response completing this cycle is applied
    // first, so a coincident DMI capture sees the FSM as Idle and samples the
    // post-completion data/dmistat; hard-reset sources are applied last.
    always_comb begin
        state_d    = state_q;
        dmistat_d  = dmistat_q;
        addr_d     = addr_q;
        data_d     = data_q;
        op_d       = op_q;
        completing = 1'b0;
`ifdef DTM_DMI_HARDRESET_EN
        hardreset_d = 1'b0;
`endif

        unique case (state_q)
            StReq: begin
                if (dmi_req_ready_i) state_d = StWait;
            end
            StWait: begin
                if (dmi_resp_valid_i) begin
                    completing = 1'b1;
                    state_d    = StIdle;
                    if (op_q == DmiRead) data_d = dmi_resp_data_i;
                    if (dmistat_d == 2'd0) dmistat_d = dmi_resp_op_i;
                end
            end
            default: ;
        endcase

        busy_now = (state_q != StIdle) && !completing;

        if (dmi_cap && busy_now && (dmistat_d == 2'd0)) dmistat_d = DmiBusy;
        dmi_cap_data = {addr_q, data_d, dmistat_d};

        if (dmi_upd && (dmistat_d == 2'd0)) begin
            if (busy_now) begin
                dmistat_d = DmiBusy;
            end else if ((upd_op == DmiRead) || (upd_op == DmiWrite)) begin
                addr_d  = dmi_sr[DmiWidth-1:34];
                data_d  = dmi_sr[33:2];
                op_d    = upd_op;
                state_d = StReq;
            end
        end

        if (dtmcs_upd) begin
            if (dtmcs_sr[16]) dmistat_d = '0;
`ifdef DTM_DMI_HARDRESET_EN
            if (dtmcs_sr[17]) begin
                dmistat_d   = '0;
                state_d     = StIdle;
                hardreset_d = 1'b1;
            end
`endif
        end

        if (dmi_clear_i) begin
            dmistat_d = '0;
            state_d   = StIdle;
`ifdef DTM_DMI_HARDRESET_EN
            hardreset_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q   <= StIdle;
            dmistat_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            op_q      <= '0;
        end else begin
            state_q   <= state_d;
            dmistat_q <= dmistat_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            op_q      <= op_d;
        end
    end

`ifdef DTM_DMI_HARDRESET_EN
    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            hardreset_q <= 1'b0;
        end else begin
            hardreset_q <= hardreset_d;
        end
    end
    assign dmi_hardreset_o = hardreset_q;
`else
    assign dmi_hardreset_o = 1'b0;
`endif

    dtm_shift_reg #(.Width(32)) u_dtmcs_sr (
        .clk_i          (tck_i),
        .rst_ni         (trst_ni),
        .clear_i        (dmi_clear_i),
        .capture_i      (dtmcs_cap),
        .shift_i        (shift_i & dtmcs_select_i),
        .tdi_i          (tdi_i),
        .capture_data_i (dtmcs_cap_data),
        .q_o            (dtmcs_sr),
        .tdo_o          (dtmcs_tdo_o)
    );

    dtm_shift_reg #(.Width(DmiWidth)) u_dmi_sr (
        .clk_i          (tck_i),
        .rst_ni         (trst_ni),
        .clear_i        (dmi_clear_i),
        .capture_i      (dmi_cap),
        .shift_i        (shift_i & dmi_select_i),
        .tdi_i          (tdi_i),
        .capture_data_i (dmi_cap_data),
        .q_o            (dmi_sr),
        .tdo_o          (dmi_tdo_o)
    );

    assign dmi_req_valid_o  = (state_q == StReq);
    assign dmi_resp_ready_o = (state_q == StWait);
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_req_op_o     = op_q;

endmodule

// File: doc/dtm_dmi_ctrl.md
# dtm_dmi_ctrl

DMI access controller for the JTAG debug transport module, clocked on TCK. It owns the DTMCS and DMI data registers selected by the TAP controller and shifts them using the TAP's capture/shift/update strobes. It sequences each DMI update-DR into a valid/ready request/response transaction toward the debug module. It keeps the sticky `dmistat` error state defined by RISC-V Debug Spec 0.13.

## Interface
- `AddrWidth`, 7: DMI address bits. Reported in `dtmcs.abits`.
- `IdleCycles`, 1: value reported in `dtmcs.idle` (3 bits).
- `tck_i` in 1: JTAG clock; all state updates on posedge.
- `trst_ni` in 1: reset, asynchronous, active-low.
- `dmi_clear_i` in 1: TAP Test-Logic-Reset; equivalent to a hard reset.
- `capture_i` / `shift_i` / `update_i` in 1 each: TAP DR strobes, one-cycle qualifiers.
- `tdi_i` in 1: serial data in.
- `dtmcs_select_i` in 1: DTMCS is the selected DR.
- `dtmcs_tdo_o` out 1: DTMCS shift LSB.
- `dmi_select_i` in 1: DMI is the selected DR.
- `dmi_tdo_o` out 1: DMI shift LSB.
- `dmi_req_valid_o` out 1: request valid.
- `dmi_req_ready_i` in 1: request accepted.
- `dmi_req_addr_o` out AddrWidth: request address.
- `dmi_req_data_o` out 32: request write data.
- `dmi_req_op_o` out 2: request op; 1 = read, 2 = write.
- `dmi_resp_valid_i` in 1: response valid.
- `dmi_resp_ready_o` out 1: response accepted.
- `dmi_resp_data_i` in 32: response read data.
- `dmi_resp_op_i` in 2: response status; 0 = ok, 2 = failed, 3 = busy.
- `dmi_hardreset_o` out 1: one-cycle pulse on hard reset.

## Operation
**DMI register layout**
- DMI DR is `AddrWidth+34` bits, packed as {addr, data[31:0], op[1:0]}, shifted LSB-first.
- Capture (`capture_i & dmi_select_i`):
  - If the FSM is not Idle, set `dmistat` to 3 first.
  - Load {addr_q, data_q, dmistat}.
- Shift (`shift_i & dmi_select_i`): `sr <= {tdi_i, sr[N-1:1]}`.

**DMI update** (`update_i & dmi_select_i`), checked in this order:
1. `dmistat != 0`: ignore.
2. FSM not Idle: set `dmistat` to 3 and ignore.
3. op = 1 or 2: latch addr/data/op, go to Req.
4. op = 0 or 3: no action.

**FSM states**
- Idle: no transaction outstanding.
- Req: `dmi_req_valid_o` = 1. Addr/data/op held stable until `dmi_req_ready_i`; then go to Wait.
- Wait: `dmi_resp_ready_o` = 1. On `dmi_resp_valid_i`:
  - Latch `dmi_resp_data_i` into data_q when op was read.
  - Set `dmistat` to `dmi_resp_op_i` if it is nonzero.
  - Go to Idle.

**DTMCS register**
- 32 bits: [3:0] version = 1; [9:4] abits = `AddrWidth`; [11:10] dmistat; [14:12] idle = `IdleCycles`; others read 0.
- Capture loads this value. Shift works as for DMI.
- Update, bit 16 (dmireset): `dmistat` <= 0.
- Update, bit 17 (dmihardreset), or `dmi_clear_i`:
  - `dmistat` <= 0.
  - FSM forced to Idle; `dmi_req_valid_o` and `dmi_resp_ready_o` drop the next cycle.
  - `dmi_hardreset_o` pulses for one cycle.
  - The debug module must discard an abandoned transaction.

**dmistat rules**
- Sticky; a nonzero value is never overwritten by another nonzero value.
- The only clears are dmireset, hard reset and trst.

## Timing
- Reset values of outputs (trst_ni low): both tdo outputs 0, `dmi_req_valid_o` 0, `dmi_resp_ready_o` 0, addr/data/op 0, `dmi_hardreset_o` 0.
- Reset values of internal state: FSM Idle, `dmistat` 0, shift registers 0.
- `dmtcs_tdo_o` and `dmi_tdo_o` are combinational from shift reg bit 0. The TAP registers TDO.
- `dmi_req_valid_o` rises the cycle after the update strobe.
- The earliest response is the cycle after request acceptance (a same-cycle ready is accepted).
- Simultaneous DMI capture and transaction completion in the same cycle: completion wins. FSM treated as Idle, no busy is set, captured op = updated `dmistat`.
- Simultaneous `dmi_clear_i` and any strobe: clear wins.
- trst mid-transaction: immediate abandon; no `dmi_hardreset_o` pulse.

## Configuration
- Macro `DTM_DMI_HARDRESET_EN`.
- Defined: dmihardreset (DTMCS bit 17) behaves as above.
- Undefined: bit 17 is ignored and `dmi_hardreset_o` is tied 0. `dmi_clear_i` still performs the abort.

## Structure
- Shared package `dtm_pkg` holds:
  - DMI op enum (NOP = 0, READ = 1, WRITE = 2).
  - Response/status enum (OK = 0, FAILED = 2, BUSY = 3).
  - DTMCS field typedef (packed struct).
  - FSM state enum (Idle, Req, Wait).
  - Constant `DtmVersion` = 1.
- One sub-module, `dtm_shift_reg`, parameterised by width: capture load, shift, LSB out. Instantiated once for DTMCS and once for DMI.

## Test plan
- DTMCS read after reset with `AddrWidth`=7 → captured value 0x00001071.
- DMI write addr 0x10, data 0xDEADBEEF, op 2 → one request with those fields. With response op 0, the next capture shows op 0.
- DMI read addr 0x11 with response data 0x12345678 → the following capture returns data 0x12345678, op 0.
- Update while in Wait → next capture op 3. A further write is ignored (no request) until DTMCS bit 16 is written; then op reads 0.
- Response op 2 → sticky op 2 across two captures; cleared by dmireset.
- DTMCS bit 17 written while in Req → `dmi_req_valid_o` drops the next cycle and `dmi_hardreset_o` pulses one cycle. Without the macro: no pulse and the request stays.
